// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - stepper STEP/DIR pulse generator spreading a division remainder across steps
module step_pulse_gen #(
    parameter int M  = 9,
    parameter int N  = 4,
    parameter int PW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dir,
    input  logic [N:0]   steps,
    input  logic [M:0]   quo,
    input  logic [M:0]   rem,
    input  logic         error_in,
    input  logic         abort,
    output logic         step,
    output logic         dir_o,
    output logic         busy,
    output logic         done,
    output logic         fault
);

    // Wide enough for acc + rem and for quo + 1 without wrap.
    localparam int AW = ((M > N) ? M : N) + 2;
    localparam logic [AW-1:0] P_MIN    = AW'(2 * PW);
    localparam logic [AW-1:0] HIGH_CNT = AW'(PW - 1);
    localparam logic [AW-1:0] LOW_ADJ  = AW'(PW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          enter_high;

    logic [N:0]    steps_l;
    logic [M:0]    quo_l;
    logic [M:0]    rem_l;
    logic [N:0]    left;
    logic [AW-1:0] acc;
    logic [AW-1:0] per_l;
    logic [AW-1:0] cnt;
    logic          cnt_zero;

    logic [AW-1:0] acc_sum;
    logic [AW-1:0] steps_ext;
    logic          extra;
    logic [AW-1:0] acc_nxt;
    logic [AW-1:0] per_raw;
    logic [AW-1:0] per_nxt;

    assign cnt_zero = (cnt == '0);

    // Bresenham accumulator: one extra cycle whenever the carried remainder reaches steps.
    always_comb begin
        acc_sum   = acc + {{(AW-M-1){1'b0}}, rem_l};
        steps_ext = {{(AW-N-1){1'b0}}, steps_l};
        extra     = (acc_sum >= steps_ext);
        acc_nxt   = extra ? (acc_sum - steps_ext) : acc_sum;
        per_raw   = {{(AW-M-1){1'b0}}, quo_l} + {{(AW-1){1'b0}}, extra};
        per_nxt   = (per_raw < P_MIN) ? P_MIN : per_raw;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks step-count completion.
    always_comb begin
        state_nxt  = state;
        enter_high = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (error_in || (steps == '0)) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt  = S_HIGH;
                    enter_high = 1'b1;
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (cnt_zero) begin
                    state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (cnt_zero) begin
                    if (left == (N+1)'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt  = S_HIGH;
                        enter_high = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, fault flag and direction, updated only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_l <= '0;
            quo_l   <= '0;
            rem_l   <= '0;
            dir_o   <= 1'b0;
            fault   <= 1'b0;
        end else if (state == S_IDLE && start) begin
            fault <= error_in;
            if (!error_in && (steps != '0)) begin
                steps_l <= steps;
                quo_l   <= quo;
                rem_l   <= rem;
                dir_o   <= dir;
            end
        end
    end

    // Per-step accumulator and period, refreshed on every entry into HIGH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            per_l <= '0;
        end else if (state == S_IDLE && start) begin
            acc <= '0;
        end else if (enter_high) begin
            acc   <= acc_nxt;
            per_l <= per_nxt;
        end
    end

    // Phase counter: PW cycles high, then the rest of the period low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (enter_high) begin
            cnt <= HIGH_CNT;
        end else if (state == S_HIGH && cnt_zero) begin
            cnt <= per_l - LOW_ADJ;
        end else if ((state == S_HIGH || state == S_LOW) && !cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Remaining-step counter, decremented at the end of each LOW phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left <= '0;
        end else if (state == S_IDLE && start && !error_in && (steps != '0)) begin
            left <= steps;
        end else if (state == S_LOW && cnt_zero && !abort) begin
            left <= left - 1'b1;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            step <= (state_nxt == S_HIGH);
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb/tb_step_pulse_gen.sv - directed self-checking bench for step_pulse_gen
module tb_step_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       dir;
    logic [4:0] steps;
    logic [9:0] quo;
    logic [9:0] rem;
    logic       error_in;
    logic       abort;
    logic       step;
    logic       dir_o;
    logic       busy;
    logic       done;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ts = 0;
    int rises[$];
    int high_lens[$];
    int hl = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int busy_cnt = 0;
    logic step_d = 1'b0;

    step_pulse_gen #(.M(9), .N(4), .PW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dir      (dir),
        .steps    (steps),
        .quo      (quo),
        .rem      (rem),
        .error_in (error_in),
        .abort    (abort),
        .step     (step),
        .dir_o    (dir_o),
        .busy     (busy),
        .done     (done),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (step && !step_d) rises.push_back(cyc);
        if (step) hl = hl + 1;
        else if (step_d) begin
            high_lens.push_back(hl);
            hl = 0;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        step_d = step;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rise_off(input int i);
        if (i < rises.size()) return rises[i] - ts;
        return -1;
    endfunction

    function automatic int rise_gap(input int i);
        if (i + 1 < rises.size()) return rises[i+1] - rises[i];
        return -1;
    endfunction

    function automatic int hlen(input int i);
        if (i < high_lens.size()) return high_lens[i];
        return -1;
    endfunction

    task automatic clear_stats();
        rises.delete();
        high_lens.delete();
        hl = 0;
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
    endtask

    // Pulses start for one cycle, then scrambles the operands to prove latching.
    task automatic launch(input int s, input int q, input int r, input logic d, input logic e);
        @(posedge clk); #1;
        clear_stats();
        steps = 5'(s); quo = 10'(q); rem = 10'(r); dir = d; error_in = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ts = cyc;
        steps = 5'd31; quo = 10'd1; rem = 10'd7; dir = ~d; error_in = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (done_cnt == 0 && i < 500) begin
            @(posedge clk);
            i++;
        end
        chk("done_seen", int'(done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; quo = '0; rem = '0;
        error_in = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step", int'(step), 0);
        chk("rst_dir", int'(dir_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1'b1;

        // Four steps, remainder 2 spread as periods 10,11,10,11.
        launch(4, 10, 2, 1'b1, 1'b0);
        wait_done();
        chk("t1_pulses", rises.size(), 4);
        chk("t1_first", rise_off(0), 1);
        chk("t1_gap0", rise_gap(0), 10);
        chk("t1_gap1", rise_gap(1), 11);
        chk("t1_gap2", rise_gap(2), 10);
        chk("t1_last_to_done", done_cyc - rises[rises.size()-1], 11);
        chk("t1_hi0", hlen(0), 4);
        chk("t1_hi3", hlen(3), 4);
        chk("t1_done_off", done_cyc - ts, 43);
        chk("t1_busy_len", busy_cnt, 44);
        chk("t1_dir", int'(dir_o), 1);
        chk("t1_fault", int'(fault), 0);

        // Zero steps: immediate done, busy for one cycle, dir untouched.
        launch(0, 10, 0, 1'b0, 1'b0);
        wait_done();
        chk("t2_pulses", rises.size(), 0);
        chk("t2_done_off", done_cyc - ts, 0);
        chk("t2_busy_len", busy_cnt, 1);
        chk("t2_fault", int'(fault), 0);
        chk("t2_dir", int'(dir_o), 1);

        // Divider error: fault set, no pulses; next good start clears it.
        launch(3, 10, 0, 1'b0, 1'b1);
        wait_done();
        chk("t3_pulses", rises.size(), 0);
        chk("t3_fault", int'(fault), 1);
        chk("t3_dir", int'(dir_o), 1);
        launch(1, 10, 0, 1'b0, 1'b0);
        wait_done();
        chk("t3b_fault", int'(fault), 0);
        chk("t3b_pulses", rises.size(), 1);
        chk("t3b_done_off", done_cyc - ts, 11);
        chk("t3b_dir", int'(dir_o), 0);

        // Short quotient clamped to the 2*PW minimum period.
        launch(3, 3, 0, 1'b1, 1'b0);
        wait_done();
        chk("t4_pulses", rises.size(), 3);
        chk("t4_gap0", rise_gap(0), 8);
        chk("t4_gap1", rise_gap(1), 8);
        chk("t4_done_off", done_cyc - ts, 25);

        // Abort in the second HIGH phase.
        launch(5, 10, 0, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("t5_step_after_abort", int'(step), 0);
        chk("t5_done_now", int'(done), 1);
        wait_done();
        chk("t5_pulses", rises.size(), 2);
        chk("t5_hi1", hlen(1), 2);
        chk("t5_done_off", done_cyc - ts, 13);
        chk("t5_dir", int'(dir_o), 1);

        // Start mid-move with different operands is ignored.
        launch(2, 8, 0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; dir = 1'b1; steps = 5'd5; quo = 10'd3;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t6_dir_mid", int'(dir_o), 0);
        wait_done();
        chk("t6_pulses", rises.size(), 2);
        chk("t6_gap0", rise_gap(0), 8);
        chk("t6_done_off", done_cyc - ts, 17);
        chk("t6_dir", int'(dir_o), 0);

        // Asynchronous reset mid-HIGH.
        launch(3, 10, 0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("t7_step_pre", int'(step), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_step", int'(step), 0);
        chk("t7_busy", int'(busy), 0);
        chk("t7_dir", int'(dir_o), 0);
        chk("t7_fault", int'(fault), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t7_idle_step", int'(step), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
